// File: rtl/bp_tlb_mru_if.sv
`default_nettype none
// ============================================================================
//  Module   : bp_tlb_mru_if
//  Brief    : Lookup / miss / fill bundle of the bp_tlb_mru TLB; perf counter
//             outputs present only when BP_TLB_MRU_PERF_CNT_EN is defined.
//  Revision : 1.0
// ============================================================================
interface bp_tlb_mru_if #(
   parameter int vtag_width_p  = 27,
   parameter int entry_width_p = 36
);
   logic                     flush_i;
   logic                     translation_en_i;
   logic                     r_v_i;
   logic                     r_ready_o;
   logic [vtag_width_p-1:0]  r_vtag_i;
   logic                     r_v_o;
   logic [entry_width_p-1:0] r_entry_o;
   logic                     r_mru_hit_o;
   logic                     miss_v_o;
   logic [vtag_width_p-1:0]  miss_vtag_o;
   logic                     fill_v_i;
   logic [vtag_width_p-1:0]  fill_vtag_i;
   logic [entry_width_p-1:0] fill_entry_i;
`ifdef BP_TLB_MRU_PERF_CNT_EN
   logic [31:0]              perf_mru_hit_o;
   logic [31:0]              perf_main_hit_o;
   logic [31:0]              perf_miss_o;
`endif

   modport slave (
`ifdef BP_TLB_MRU_PERF_CNT_EN
      output perf_mru_hit_o, perf_main_hit_o, perf_miss_o,
`endif
      input  flush_i, translation_en_i, r_v_i, r_vtag_i,
      input  fill_v_i, fill_vtag_i, fill_entry_i,
      output r_ready_o, r_v_o, r_entry_o, r_mru_hit_o, miss_v_o, miss_vtag_o
   );

   modport master (
`ifdef BP_TLB_MRU_PERF_CNT_EN
      input  perf_mru_hit_o, perf_main_hit_o, perf_miss_o,
`endif
      output flush_i, translation_en_i, r_v_i, r_vtag_i,
      output fill_v_i, fill_vtag_i, fill_entry_i,
      input  r_ready_o, r_v_o, r_entry_o, r_mru_hit_o, miss_v_o, miss_vtag_o
   );
endinterface
`default_nettype wire

// File: rtl/bp_tlb_mru.sv
`default_nettype none
// ============================================================================
//  Module   : bp_tlb_mru
//  Brief    : Fully associative TLB with an N-deep true-LRU MRU bypass and a
//             blocking miss/fill FSM. Optional counters: BP_TLB_MRU_PERF_CNT_EN.
//  Revision : 1.0
// ============================================================================
module bp_tlb_mru #(
   parameter int els_p         = 8,
   parameter int mru_els_p     = 2,
   parameter int vtag_width_p  = 27,
   parameter int ptag_width_p  = 28,
   parameter int entry_width_p = 36
) (
   input  logic        clk_i,
   input  logic        reset_n_i,
   bp_tlb_mru_if.slave bus
);
   localparam int IDX_W = $clog2(els_p);

   typedef logic [vtag_width_p-1:0]  vtag_t;
   typedef logic [ptag_width_p-1:0]  ptag_t;
   typedef logic [entry_width_p-1:0] entry_t;
   typedef logic [IDX_W-1:0]         idx_t;

   typedef enum logic [0:0] {IDLE = 1'b0, MISS = 1'b1} state_e;

   state_e               state, state_n;
   logic [els_p-1:0]     main_v, main_v_n;
   vtag_t                main_vtag   [els_p];
   vtag_t                main_vtag_n [els_p];
   entry_t               main_entry  [els_p];
   entry_t               main_entry_n[els_p];
   logic [mru_els_p-1:0] mru_v, mru_v_n;
   vtag_t                mru_vtag    [mru_els_p];
   vtag_t                mru_vtag_n  [mru_els_p];
   entry_t               mru_entry   [mru_els_p];
   entry_t               mru_entry_n [mru_els_p];
   idx_t                 victim, victim_n;
   logic                 res_v, res_v_n;
   logic                 res_mru, res_mru_n;
   entry_t               res_entry, res_entry_n;
   vtag_t                miss_vtag, miss_vtag_n;

   logic   fill_eff, accept;
   logic   fill_found, inv_found;
   idx_t   fill_idx, inv_idx, wr_idx;
   logic   main_hit, mru_hit;
   entry_t main_hit_entry, mru_hit_entry;
   logic   upd_mru, k_found;
   vtag_t  upd_vtag;
   entry_t upd_entry;
   int     hit_k;
   entry_t pass_entry;

   // Passthrough: vtag resized to the ptag field, permission bits zero.
   assign pass_entry = entry_t'(ptag_t'(bus.r_vtag_i));

   assign fill_eff = bus.fill_v_i & bus.translation_en_i;
   assign accept   = bus.r_v_i & (state == IDLE);

   always_comb begin
      state_n        = state;
      main_v_n       = main_v;
      main_vtag_n    = main_vtag;
      main_entry_n   = main_entry;
      mru_v_n        = mru_v;
      mru_vtag_n     = mru_vtag;
      mru_entry_n    = mru_entry;
      victim_n       = victim;
      res_v_n        = 1'b0;
      res_mru_n      = 1'b0;
      res_entry_n    = res_entry;
      miss_vtag_n    = miss_vtag;
      fill_found     = 1'b0;
      inv_found      = 1'b0;
      fill_idx       = '0;
      inv_idx        = '0;
      wr_idx         = '0;
      main_hit       = 1'b0;
      mru_hit        = 1'b0;
      main_hit_entry = '0;
      mru_hit_entry  = '0;
      upd_mru        = 1'b0;
      upd_vtag       = '0;
      upd_entry      = '0;
      k_found        = 1'b0;
      hit_k          = 0;

      for (int i = 0; i < els_p; i++) begin
         if (!fill_found && main_v[i] && (main_vtag[i] == bus.fill_vtag_i)) begin
            fill_found = 1'b1;
            fill_idx   = idx_t'(i);
         end
         if (!inv_found && !main_v[i]) begin
            inv_found = 1'b1;
            inv_idx   = idx_t'(i);
         end
      end

      // The fill is applied first so a same-cycle lookup sees the written array.
      if (fill_eff) begin
         if (fill_found) begin
            wr_idx = fill_idx;
         end else if (inv_found) begin
            wr_idx = inv_idx;
         end else begin
            wr_idx   = victim;
            victim_n = (victim == idx_t'(els_p - 1)) ? '0 : victim + 1'b1;
         end
         main_v_n[wr_idx]     = 1'b1;
         main_vtag_n[wr_idx]  = bus.fill_vtag_i;
         main_entry_n[wr_idx] = bus.fill_entry_i;
         for (int i = 0; i < mru_els_p; i++) begin
            if (mru_v[i] && (mru_vtag[i] == bus.fill_vtag_i)) begin
               mru_entry_n[i] = bus.fill_entry_i;
            end
         end
      end

      for (int i = 0; i < mru_els_p; i++) begin
         if (mru_v_n[i] && (mru_vtag_n[i] == bus.r_vtag_i)) begin
            mru_hit       = 1'b1;
            mru_hit_entry = mru_entry_n[i];
         end
      end
      for (int i = 0; i < els_p; i++) begin
         if (main_v_n[i] && (main_vtag_n[i] == bus.r_vtag_i)) begin
            main_hit       = 1'b1;
            main_hit_entry = main_entry_n[i];
         end
      end

      if (state == IDLE) begin
         if (accept) begin
            if (!bus.translation_en_i) begin
               res_v_n     = 1'b1;
               res_entry_n = pass_entry;
            end else if (fill_eff && (bus.fill_vtag_i == bus.r_vtag_i)) begin
               res_v_n     = 1'b1;
               res_entry_n = bus.fill_entry_i;
               upd_mru     = 1'b1;
               upd_vtag    = bus.r_vtag_i;
               upd_entry   = bus.fill_entry_i;
            end else if (mru_hit) begin
               res_v_n     = 1'b1;
               res_mru_n   = 1'b1;
               res_entry_n = mru_hit_entry;
               upd_mru     = 1'b1;
               upd_vtag    = bus.r_vtag_i;
               upd_entry   = mru_hit_entry;
            end else if (main_hit) begin
               res_v_n     = 1'b1;
               res_entry_n = main_hit_entry;
               upd_mru     = 1'b1;
               upd_vtag    = bus.r_vtag_i;
               upd_entry   = main_hit_entry;
            end else begin
               state_n     = MISS;
               miss_vtag_n = bus.r_vtag_i;
            end
         end
      end else begin
         if (fill_eff && (bus.fill_vtag_i == miss_vtag)) begin
            res_v_n     = 1'b1;
            res_entry_n = bus.fill_entry_i;
            state_n     = IDLE;
            upd_mru     = 1'b1;
            upd_vtag    = miss_vtag;
            upd_entry   = bus.fill_entry_i;
         end
      end

      // LRU reorder: slots above the existing copy (or all, if absent) shift down.
      if (upd_mru) begin
         hit_k = mru_els_p - 1;
         for (int i = 0; i < mru_els_p; i++) begin
            if (!k_found && mru_v_n[i] && (mru_vtag_n[i] == upd_vtag)) begin
               k_found = 1'b1;
               hit_k   = i;
            end
         end
         for (int i = mru_els_p - 1; i > 0; i--) begin
            if (i <= hit_k) begin
               mru_v_n[i]     = mru_v_n[i-1];
               mru_vtag_n[i]  = mru_vtag_n[i-1];
               mru_entry_n[i] = mru_entry_n[i-1];
            end
         end
         mru_v_n[0]     = 1'b1;
         mru_vtag_n[0]  = upd_vtag;
         mru_entry_n[0] = upd_entry;
      end

      if (bus.flush_i) begin
         main_v_n  = '0;
         mru_v_n   = '0;
         victim_n  = '0;
         state_n   = IDLE;
         res_v_n   = 1'b0;
         res_mru_n = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state     <= IDLE;
         main_v    <= '0;
         mru_v     <= '0;
         victim    <= '0;
         res_v     <= 1'b0;
         res_mru   <= 1'b0;
         res_entry <= '0;
         miss_vtag <= '0;
         for (int i = 0; i < els_p; i++) begin
            main_vtag[i]  <= '0;
            main_entry[i] <= '0;
         end
         for (int i = 0; i < mru_els_p; i++) begin
            mru_vtag[i]  <= '0;
            mru_entry[i] <= '0;
         end
      end else begin
         state      <= state_n;
         main_v     <= main_v_n;
         main_vtag  <= main_vtag_n;
         main_entry <= main_entry_n;
         mru_v      <= mru_v_n;
         mru_vtag   <= mru_vtag_n;
         mru_entry  <= mru_entry_n;
         victim     <= victim_n;
         res_v      <= res_v_n;
         res_mru    <= res_mru_n;
         res_entry  <= res_entry_n;
         miss_vtag  <= miss_vtag_n;
      end
   end

   assign bus.r_ready_o   = (state == IDLE);
   assign bus.r_v_o       = res_v;
   assign bus.r_entry_o   = res_entry;
   assign bus.r_mru_hit_o = res_mru;
   assign bus.miss_v_o    = (state == MISS);
   assign bus.miss_vtag_o = miss_vtag;

`ifdef BP_TLB_MRU_PERF_CNT_EN
   logic [31:0] cnt_mru, cnt_main, cnt_miss;
   logic        inc_mru, inc_main, inc_miss;

   // Passthrough results and miss completions are not counted as hits.
   assign inc_mru  = res_v_n & res_mru_n;
   assign inc_main = res_v_n & ~res_mru_n & (state == IDLE) & bus.translation_en_i;
   assign inc_miss = (state == IDLE) & (state_n == MISS);

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         cnt_mru  <= '0;
         cnt_main <= '0;
         cnt_miss <= '0;
      end else begin
         if (inc_mru  && (cnt_mru  != '1)) cnt_mru  <= cnt_mru  + 1'b1;
         if (inc_main && (cnt_main != '1)) cnt_main <= cnt_main + 1'b1;
         if (inc_miss && (cnt_miss != '1)) cnt_miss <= cnt_miss + 1'b1;
      end
   end

   assign bus.perf_mru_hit_o  = cnt_mru;
   assign bus.perf_main_hit_o = cnt_main;
   assign bus.perf_miss_o     = cnt_miss;
`endif

endmodule
`default_nettype wire
